// File: rtl/icache_line_fill.sv
// icache_line_fill: memory-side line-fill engine for the wide instruction cache.
// Takes one line request, reads NUM_BLOCKS words over a narrow valid/ready memory
// bus, assembles them into one line and returns it with a single-cycle ready pulse.
// Optional feature: define ICACHE_LINE_FILL_LAST_BUF_EN to keep the last completed
// line so that a repeat request for the same base is answered without memory reads.
module icache_line_fill #(
  parameter int NUM_BLOCKS = 4,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 line_req_valid,
  output logic                                 line_req_ready,
  input  logic [31:0]                          line_req_addr,
  output logic [8*BLOCK_SIZE*NUM_BLOCKS-1:0]   line_req_rdata,
  output logic                                 mem_valid,
  input  logic                                 mem_ready,
  output logic [31:0]                          mem_addr,
  input  logic [8*BLOCK_SIZE-1:0]              mem_rdata,
  output logic                                 fill_busy
);

  localparam int W  = 8 * BLOCK_SIZE;
  localparam int LW = W * NUM_BLOCKS;
  localparam int LB = $clog2(NUM_BLOCKS * BLOCK_SIZE);
  localparam int OB = $clog2(BLOCK_SIZE);
  localparam int CW = $clog2(NUM_BLOCKS);
  localparam logic [31:0]   LINE_MASK = ~((32'd1 << LB) - 32'd1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NUM_BLOCKS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_FETCH = 3'd2,
    ST_RESP  = 3'd3,
    ST_DROP  = 3'd4
  } state_t;

  // Registered state
  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [31:0]      r_base;
  logic             r_abort;
  logic             r_mem_valid;
  logic [31:0]      r_mem_addr;
  logic             r_ready;
  logic             r_busy;
  logic [LW-1:0]    r_line;

  // Next-state values
  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [31:0]      w_base_nxt;
  logic             w_abort_nxt;
  logic             w_abort_now;
  logic             w_mem_valid_nxt;
  logic [31:0]      w_mem_addr_nxt;
  logic             w_ready_nxt;
  logic             w_beat_wr;
  logic             w_load_buf;
  logic             w_buf_hit;
  logic [LW-1:0]    w_buf_line;

  // Word address of a beat: base low bits are zero, so OR-ing the offset
  // never carries out of the line.
  function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                            input logic [CW-1:0] cnt);
    return base | (32'(cnt) << OB);
  endfunction

  // A fill is abandoned once the cache withdraws its request during ISSUE/FETCH
  assign w_abort_now = r_abort | ~line_req_valid;

  // Next-state and next-output decode for the fill sequencer
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_base_nxt      = r_base;
    w_abort_nxt     = r_abort;
    w_mem_valid_nxt = r_mem_valid;
    w_mem_addr_nxt  = r_mem_addr;
    w_ready_nxt     = 1'b0;
    w_beat_wr       = 1'b0;
    w_load_buf      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_abort_nxt     = 1'b0;
        w_mem_valid_nxt = 1'b0;
        if (line_req_valid) begin
          w_base_nxt = line_req_addr & LINE_MASK;
          w_cnt_nxt  = '0;
          if (w_buf_hit) begin
            w_state_nxt = ST_RESP;
            w_ready_nxt = 1'b1;
            w_load_buf  = 1'b1;
          end else begin
            w_state_nxt = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_abort_now) begin
          // No beat is outstanding here, so the fill can stop immediately
          w_state_nxt     = ST_IDLE;
          w_abort_nxt     = 1'b0;
          w_mem_valid_nxt = 1'b0;
        end else begin
          w_state_nxt     = ST_FETCH;
          w_mem_valid_nxt = 1'b1;
          w_mem_addr_nxt  = beat_addr(r_base, r_cnt);
        end
      end
      ST_FETCH: begin
        w_abort_nxt = w_abort_now;
        if (mem_ready) begin
          w_beat_wr       = 1'b1;
          w_mem_valid_nxt = 1'b0;
          if (w_abort_now) begin
            w_state_nxt = ST_IDLE;
            w_abort_nxt = 1'b0;
          end else if (r_cnt == LAST_BEAT) begin
            w_state_nxt = ST_RESP;
            w_ready_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end else begin
          // Beat in flight: request must stay asserted and stable
          w_state_nxt     = ST_FETCH;
          w_mem_valid_nxt = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_DROP;
      end
      ST_DROP: begin
        if (!line_req_valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_abort_nxt     = 1'b0;
        w_mem_valid_nxt = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered bus/handshake outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_base      <= 32'd0;
      r_abort     <= 1'b0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_base      <= w_base_nxt;
      r_abort     <= w_abort_nxt;
      r_mem_valid <= w_mem_valid_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_ready     <= w_ready_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Line assembly: drop each accepted word into its slot, or load the buffered line on a hit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_line <= '0;
    end else if (w_load_buf) begin
      r_line <= w_buf_line;
    end else if (w_beat_wr) begin
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        if (r_cnt == CW'(k)) begin
          r_line[k*W +: W] <= mem_rdata;
        end else begin
          r_line[k*W +: W] <= r_line[k*W +: W];
        end
      end
    end else begin
      r_line <= r_line;
    end
  end

`ifdef ICACHE_LINE_FILL_LAST_BUF_EN
  logic          r_buf_valid;
  logic [31:0]   r_buf_base;
  logic [LW-1:0] r_buf_line;

  // Last-line buffer: remember every line that reaches the response state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf_valid <= 1'b0;
      r_buf_base  <= 32'd0;
      r_buf_line  <= '0;
    end else if (r_state == ST_RESP) begin
      r_buf_valid <= 1'b1;
      r_buf_base  <= r_base;
      r_buf_line  <= r_line;
    end else begin
      r_buf_valid <= r_buf_valid;
      r_buf_base  <= r_buf_base;
      r_buf_line  <= r_buf_line;
    end
  end

  assign w_buf_hit  = r_buf_valid && ((line_req_addr & LINE_MASK) == r_buf_base);
  assign w_buf_line = r_buf_line;
`else
  assign w_buf_hit  = 1'b0;
  assign w_buf_line = '0;
`endif

  assign line_req_ready = r_ready;
  assign line_req_rdata = r_line;
  assign mem_valid      = r_mem_valid;
  assign mem_addr       = r_mem_addr;
  assign fill_busy      = r_busy;

endmodule
